// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the saturating sum accumulator and its
// optional seven-segment display path.
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } state_t;

    // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG7_SAT = 7'h0E;

endpackage

// File: rtl/sum_accumulator_if.sv
// Bundles the adder-result handshake, clear and accumulator outputs.
// seg_n exists only when SUM_ACCUMULATOR_SEG7_EN is defined.
interface sum_accumulator_if #(
    parameter int ACC_W = 6,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             s0;
    logic             s1;
    logic             co;
    logic             clr;
    logic [ACC_W-1:0] acc_out;
    logic             acc_ovf;
    logic [CNT_W-1:0] acc_cnt;
    logic             upd;
`ifdef SUM_ACCUMULATOR_SEG7_EN
    logic [6:0]       seg_n;
`endif

`ifdef SUM_ACCUMULATOR_SEG7_EN
    modport master (
        output in_valid, s0, s1, co, clr,
        input  in_ready, acc_out, acc_ovf, acc_cnt, upd, seg_n
    );
    modport slave (
        input  in_valid, s0, s1, co, clr,
        output in_ready, acc_out, acc_ovf, acc_cnt, upd, seg_n
    );
`else
    modport master (
        output in_valid, s0, s1, co, clr,
        input  in_ready, acc_out, acc_ovf, acc_cnt, upd
    );
    modport slave (
        input  in_valid, s0, s1, co, clr,
        output in_ready, acc_out, acc_ovf, acc_cnt, upd
    );
`endif

endinterface

// File: rtl/sum_accumulator_hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_seg7
    import sum_acc_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = SEG7_TABLE[hex_i];

endmodule

// File: rtl/sum_accumulator.sv
// Saturating running total of 3-bit adder results with sample counter and
// update strobe. Define SUM_ACCUMULATOR_SEG7_EN to add the seg_n display output.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 6,
    parameter int CNT_W = 4
) (
    input logic clk,
    input logic rst,
    sum_accumulator_if.slave bus
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             upd_q, upd_d;

    logic             readyInt;
    logic             transfer;
    logic [ACC_W:0]   operand;
    logic [ACC_W:0]   nextSum;

    assign readyInt = (state_q != SAT);
    assign transfer = bus.in_valid && readyInt;
    assign operand  = {{(ACC_W-2){1'b0}}, bus.co, bus.s1, bus.s0};
    // One extra bit so strict overflow past the ceiling shows up as the MSB
    assign nextSum  = {1'b0, total_q} + operand;

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        upd_d   = 1'b0;
        if (bus.clr) begin
            state_d = IDLE;
            total_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (transfer) begin
            count_d = count_q + CNT_W'(1);
            upd_d   = 1'b1;
            if (nextSum[ACC_W]) begin
                total_d = ACC_MAX;
                ovf_d   = 1'b1;
                state_d = SAT;
            end else begin
                total_d = nextSum[ACC_W-1:0];
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            total_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.in_ready = readyInt;
    assign bus.acc_out  = total_q;
    assign bus.acc_ovf  = ovf_q;
    assign bus.acc_cnt  = count_q;
    assign bus.upd      = upd_q;

`ifdef SUM_ACCUMULATOR_SEG7_EN
    logic [3:0] segNibble;
    logic [6:0] segDecoded;
    logic [6:0] seg_q;

    assign segNibble = 4'(total_d);

    hex_to_seg7 u_hex_to_seg7 (
        .hex_i   (segNibble),
        .seg_n_o (segDecoded)
    );

    // Decoded from next-state values so the display changes with acc_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG7_TABLE[0];
        end else begin
            seg_q <= (state_d == SAT) ? SEG7_SAT : segDecoded;
        end
    end

    assign bus.seg_n = seg_q;
`endif

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
Downstream stage of the 2-bit adder datapath. Consumes the adder's 3-bit result {co, s1, s0} through a valid/ready handshake and keeps a saturating running total. Also maintains a sample counter and provides a one-cycle update strobe for display and next-stage logic.

Parameters:
ACC_W, 6, accumulator width in bits (legal range 3..16); saturation ceiling is 2^ACC_W-1
CNT_W, 4, accepted-sample counter width; counter wraps modulo 2^CNT_W

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  adder result on s0/s1/co is valid this cycle
in_ready  output  1  block can accept a result this cycle
s0  input  1  adder sum bit 0
s1  input  1  adder sum bit 1
co  input  1  adder carry out (sum bit 2)
clr  input  1  synchronous clear of total, counter, flag and FSM
acc_out  output  ACC_W  registered running total
acc_ovf  output  1  sticky saturation flag
acc_cnt  output  CNT_W  number of accepted samples, mod 2^CNT_W
upd  output  1  one-cycle pulse, asserted the cycle after each accepted sample

Behaviour:
- Reset values (asynchronous, while rst=1): acc_out=0, acc_ovf=0, acc_cnt=0, upd=0, state=IDLE.
- in_ready is combinational from state only: 1 in IDLE and RUN, 0 in SAT.
- Transfer occurs when in_valid=1 and in_ready=1 at a rising clk edge.
- Operand v = {co,s1,s0}, zero-extended to ACC_W+1 bits; valid range 0..6.
- Input value 7 is illegal. It is still added as 7; no error is flagged.
- Sum is computed in ACC_W+1 bits: nxt = acc_out + v.
- FSM states:
  - IDLE: total is 0 and no sample accepted yet. On transfer: go to RUN, or to SAT if saturated.
  - RUN: on transfer, if nxt <= 2^ACC_W-1 then acc_out<=nxt and stay in RUN. Otherwise acc_out<=2^ACC_W-1, acc_ovf<=1, go to SAT.
  - SAT: no transfers. acc_out holds at max and acc_ovf stays 1. Leave only via clr or rst.
- A transfer with v=0 is still a transfer: acc_cnt increments and upd pulses.
- Latency: acc_out, acc_cnt and acc_ovf update at the accepting edge, so they are visible the next cycle. upd is high in that same next cycle, for exactly one cycle.
- acc_cnt increments on every transfer, including the saturating one, and wraps from 2^CNT_W-1 to 0.
- clr=1 at an edge: acc_out=0, acc_ovf=0, acc_cnt=0, upd=0, state=IDLE.
  - clr has priority over a simultaneous transfer; that sample is dropped.
  - in_ready is not gated by clr, so an upstream stage that sees in_ready=1 during clr must retry. Upstream holds data until accepted.
- Exact landing on the ceiling (nxt == 2^ACC_W-1) stays in RUN with acc_ovf=0. Only strict overflow saturates.
- Reset mid-operation: asynchronous return to reset values regardless of state or in_valid. in_ready becomes 1 (IDLE).
- s0/s1/co are don't-care when in_valid=0.

Optional Feature:
Macro SUM_ACCUMULATOR_SEG7_EN.
- Defined: adds output seg_n [6:0], active-low segments a..g, registered. It shows the hex digit of acc_out[3:0] and is updated in the same cycle as acc_out. During SAT it shows "F" (0x0E active-low pattern of F) regardless of value. Its reset value is the pattern for "0".
- Undefined: the port and its decoder logic are absent; everything else is identical.

Decomposition:
- Package sum_acc_pkg:
  - state enum (IDLE, RUN, SAT)
  - the 16-entry active-low seven-segment constant table
  - the SAT display constant
- One sub-module, hex_to_seg7: combinational 4-bit to 7-bit decoder, instantiated only under SUM_ACCUMULATOR_SEG7_EN.

Test Plan:
- Reset then idle: rst pulse, in_valid=0 for 5 cycles -> acc_out=0, acc_cnt=0, acc_ovf=0, in_ready=1, upd=0 throughout.
- Basic accumulate: transfers of v=3, 5, 6 on consecutive cycles -> acc_out reads 3, 8, 14 on the following cycles; upd high each of those cycles; acc_cnt=3.
- Saturation (ACC_W=6): ten transfers of 6 -> acc_out=60, state RUN. Then v=3 -> acc_out=63, acc_ovf=0. Then v=1 -> acc_out=63, acc_ovf=1, in_ready=0. Further in_valid is ignored and acc_cnt stays at 12.
- clr vs transfer: acc_out=10, assert clr and a valid v=4 in the same cycle -> next cycle acc_out=0, acc_cnt=0, upd=0, state IDLE.
- Counter wrap and zero input: 17 transfers of v=0 -> acc_out=0, acc_cnt=1, upd pulses 17 times.
- Async reset mid-run: acc_out=20, assert rst between clock edges -> outputs clear immediately, before the next edge. With SUM_ACCUMULATOR_SEG7_EN defined, seg_n shows "0", and after reaching SAT it shows "F".
